branch_predictor: RTL and testbench

Fetch-stage branch predictor and resolution tracker for the 5-stage RISC-V pipeline. It predecodes the instruction being fetched, predicts B-type branches with a PC-indexed table of 2-bit saturating counters, and predicts JAL as always taken. It carries each prediction down to MEM alongside the instruction and compares it with the datapath's resolved `pcsrc`. From that comparison it drives the datapath's `pre_branch`, `prediction`, `label`, `correct`, `error` and `new_label` inputs, and it trains the table.

---
 rtl/branch_predictor.sv | 141 ++++++++++++++
 tb/tb_branch_predictor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: predecodes B-type/JAL, predicts from a 2-bit counter
// table, tracks each prediction through D/E/M and resolves it against pcsrc in MEM.
module branch_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] instr_F,
  input  logic                  load_use_flag,
  input  logic                  pcsrc,
  output logic                  pre_branch,
  output logic                  prediction,
  output logic [DATA_WIDTH-1:0] label,
  output logic                  correct,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] new_label
);

  localparam int         ENTRIES   = 1 << INDEX_BITS;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [1:0] CTR_WNT   = 2'b01;

  typedef struct packed {
    logic                  valid;
    logic                  pred;
    logic                  is_cond;
    logic [DATA_WIDTH-1:0] pc;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, pred: 1'b0, is_cond: 1'b0,
                                   pc: {DATA_WIDTH{1'b0}}};

  // Two-bit saturating counter step toward taken or not-taken.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    return nxt;
  endfunction

  logic [1:0]            r_ctr [ENTRIES];
  slot_t                 r_d;
  slot_t                 r_e;
  slot_t                 r_m;

  logic                  w_is_b;
  logic                  w_is_jal;
  logic [DATA_WIDTH-1:0] w_imm;
  logic [INDEX_BITS-1:0] w_idx_f;
  logic [INDEX_BITS-1:0] w_idx_m;
  logic                  w_correct;
  logic                  w_error;
  logic                  w_flush;
  slot_t                 w_slot_f;

  assign w_idx_f = pc[INDEX_BITS+1:2];
  assign w_idx_m = r_m.pc[INDEX_BITS+1:2];

  // Predecode and prediction for the instruction currently being fetched.
  always_comb begin
    w_is_b     = (instr_F[6:0] == OP_BRANCH);
    w_is_jal   = (instr_F[6:0] == OP_JAL);
    w_imm      = {DATA_WIDTH{1'b0}};
    prediction = 1'b0;
    if (w_is_jal) begin
      w_imm      = {{(DATA_WIDTH-21){instr_F[31]}}, instr_F[31], instr_F[19:12],
                    instr_F[20], instr_F[30:21], 1'b0};
      prediction = 1'b1;
    end else if (w_is_b) begin
      w_imm      = {{(DATA_WIDTH-13){instr_F[31]}}, instr_F[31], instr_F[7],
                    instr_F[30:25], instr_F[11:8], 1'b0};
      prediction = r_ctr[w_idx_f][1];
    end else begin
      w_imm      = {DATA_WIDTH{1'b0}};
      prediction = 1'b0;
    end
    pre_branch = w_is_b | w_is_jal;
    label      = pc + w_imm;
  end

  // Resolution of the prediction riding in the MEM slot.
  always_comb begin
    w_correct = r_m.valid & r_m.pred & pcsrc;
    w_error   = r_m.valid & r_m.pred & ~pcsrc;
    w_flush   = (pcsrc & ~w_correct) | w_error;
    w_slot_f  = '{valid: pre_branch, pred: prediction, is_cond: w_is_b, pc: pc};
  end

  assign correct   = w_correct;
  assign error     = w_error;
  assign new_label = r_m.pc + DATA_WIDTH'(3'd4);

  // Tracking slots follow the datapath's IF/D, D/E and E/M flush/stall rules.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d <= SLOT_EMPTY;
      r_e <= SLOT_EMPTY;
      r_m <= SLOT_EMPTY;
    end else begin
      if (w_flush) begin
        r_d <= SLOT_EMPTY;
      end else if (!load_use_flag) begin
        r_d <= w_slot_f;
      end else begin
        r_d <= r_d;
      end

      if (w_flush || load_use_flag) begin
        r_e <= SLOT_EMPTY;
      end else begin
        r_e <= r_d;
      end

      if (w_flush) begin
        r_m <= SLOT_EMPTY;
      end else begin
        r_m <= r_e;
      end
    end
  end

  // Counter table: only conditional branches resolving in MEM train it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= CTR_WNT;
      end
    end else if (r_m.valid && r_m.is_cond) begin
      r_ctr[w_idx_m] <= ctr_step(r_ctr[w_idx_m], pcsrc);
    end else begin
      r_ctr[w_idx_m] <= r_ctr[w_idx_m];
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: hand-computed vectors for prediction,
// resolution, counter saturation, stall alignment and reset.
module tb_branch_predictor;

  localparam logic [31:0] BEQ    = 32'h0000_0863; // beq x0,x0,+16
  localparam logic [31:0] JAL    = 32'hFF9F_F06F; // jal x0,-8
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] BEQ_PC = 32'h0000_0100;
  localparam logic [31:0] JAL_PC = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] instr_F;
  logic        load_use_flag;
  logic        pcsrc;
  logic        pre_branch;
  logic        prediction;
  logic [31:0] label;
  logic        correct;
  logic        error;
  logic [31:0] new_label;

  int n_checks = 0;
  int n_fail   = 0;

  branch_predictor #(.DATA_WIDTH(32), .INDEX_BITS(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .instr_F       (instr_F),
    .load_use_flag (load_use_flag),
    .pcsrc         (pcsrc),
    .pre_branch    (pre_branch),
    .prediction    (prediction),
    .label         (label),
    .correct       (correct),
    .error         (error),
    .new_label     (new_label)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic [31:0] p, input logic [31:0] ins,
                       input logic lu, input logic src);
    pc            = p;
    instr_F       = ins;
    load_use_flag = lu;
    pcsrc         = src;
    #1;
  endtask

  task automatic adv();
    @(negedge clk);
  endtask

  // Fetch the BEQ, let it reach MEM, resolve it with res.
  task automatic run_br(input string tag, input logic res, input logic exp_pred);
    drive(BEQ_PC, BEQ, 1'b0, 1'b0);
    check_eq({tag, "_pred"}, {31'd0, prediction}, {31'd0, exp_pred});
    adv();
    drive(32'h104, NOP, 1'b0, 1'b0); adv();
    drive(32'h108, NOP, 1'b0, 1'b0); adv();
    drive(32'h10C, NOP, 1'b0, res);
    check_eq({tag, "_correct"}, {31'd0, correct}, {31'd0, exp_pred & res});
    check_eq({tag, "_error"},   {31'd0, error},   {31'd0, exp_pred & ~res});
    adv();
  endtask

  initial begin
    rst = 1'b1;
    drive(NOP_PC(), NOP, 1'b0, 1'b0);
    adv();
    // Reset behaviour of the prediction path.
    drive(JAL_PC, JAL, 1'b0, 1'b0);
    check_eq("rst_jal_pred", {31'd0, prediction}, 32'd1);
    drive(BEQ_PC, BEQ, 1'b0, 1'b0);
    check_eq("rst_beq_pred", {31'd0, prediction}, 32'd0);
    adv();
    rst = 1'b0;
    drive(32'h0, NOP, 1'b0, 1'b0);
    check_eq("rst_correct",   {31'd0, correct}, 32'd0);
    check_eq("rst_error",     {31'd0, error},   32'd0);
    check_eq("rst_new_label", new_label,        32'h4);
    adv();

    // First BEQ: weakly not-taken, resolves taken -> counter 10.
    drive(BEQ_PC, BEQ, 1'b0, 1'b0);
    check_eq("a0_pre_branch", {31'd0, pre_branch}, 32'd1);
    check_eq("a0_pred",       {31'd0, prediction}, 32'd0);
    check_eq("a0_label",      label,               32'h110);
    adv();
    drive(32'h104, NOP, 1'b0, 1'b0); adv();
    drive(32'h108, NOP, 1'b0, 1'b0); adv();
    drive(32'h10C, NOP, 1'b0, 1'b1);
    check_eq("a3_correct",   {31'd0, correct}, 32'd0);
    check_eq("a3_error",     {31'd0, error},   32'd0);
    check_eq("a3_new_label", new_label,        32'h104);
    adv();
    // Second BEQ predicted taken; JALs behind it must be flushed.
    drive(BEQ_PC, BEQ, 1'b0, 1'b0);
    check_eq("a4_pred", {31'd0, prediction}, 32'd1);
    adv();
    drive(JAL_PC, JAL, 1'b0, 1'b0); adv();
    drive(JAL_PC, JAL, 1'b0, 1'b0); adv();
    // Misprediction with a simultaneous stall: flush wins; same-cycle read sees old counter.
    drive(BEQ_PC, BEQ, 1'b1, 1'b0);
    check_eq("a7_error",     {31'd0, error},      32'd1);
    check_eq("a7_correct",   {31'd0, correct},    32'd0);
    check_eq("a7_new_label", new_label,           32'h104);
    check_eq("a7_pred_old",  {31'd0, prediction}, 32'd1);
    adv();
    drive(BEQ_PC, BEQ, 1'b0, 1'b0);
    check_eq("a8_pred_new", {31'd0, prediction}, 32'd0);
    adv();
    drive(32'h104, NOP, 1'b0, 1'b0);
    check_eq("a9_error", {31'd0, error}, 32'd0);
    adv();
    drive(32'h108, NOP, 1'b0, 1'b0);
    check_eq("a10_error", {31'd0, error}, 32'd0);
    adv();
    drive(32'h10C, NOP, 1'b0, 1'b1);   // BEQ from a8 resolves taken: counter 01 -> 10
    check_eq("a11_correct", {31'd0, correct}, 32'd0);
    check_eq("a11_error",   {31'd0, error},   32'd0);
    adv();

    // JAL: always taken, never trains.
    drive(JAL_PC, JAL, 1'b0, 1'b0);
    check_eq("b0_pre_branch", {31'd0, pre_branch}, 32'd1);
    check_eq("b0_pred",       {31'd0, prediction}, 32'd1);
    check_eq("b0_label",      label,               32'h1F8);
    adv();
    drive(32'h204, NOP, 1'b0, 1'b0); adv();
    drive(32'h208, NOP, 1'b0, 1'b0); adv();
    drive(32'h20C, NOP, 1'b0, 1'b1);
    check_eq("b3_correct",   {31'd0, correct}, 32'd1);
    check_eq("b3_error",     {31'd0, error},   32'd0);
    check_eq("b3_new_label", new_label,        32'h204);
    adv();

    // Counter walk starting from 10.
    run_br("r1",  1'b0, 1'b1);  // 10 -> 01
    run_br("r2",  1'b1, 1'b0);  // 01 -> 10
    run_br("r3",  1'b1, 1'b1);  // 10 -> 11
    run_br("r4",  1'b1, 1'b1);  // stays 11
    run_br("r5",  1'b1, 1'b1);  // stays 11
    run_br("r6",  1'b0, 1'b1);  // 11 -> 10
    run_br("r7",  1'b1, 1'b1);  // 10 -> 11
    run_br("r8",  1'b0, 1'b1);  // 11 -> 10
    run_br("r9",  1'b0, 1'b1);  // 10 -> 01
    run_br("r10", 1'b0, 1'b0);  // 01 -> 00
    run_br("r11", 1'b0, 1'b0);  // stays 00
    run_br("r12", 1'b1, 1'b0);  // 00 -> 01
    run_br("r13", 1'b0, 1'b0);  // 01 -> 00

    // Load-use stall while the JAL sits in slot D: arrives in MEM one cycle late.
    drive(JAL_PC, JAL, 1'b0, 1'b0); adv();
    drive(32'h204, NOP, 1'b1, 1'b0); adv();
    drive(32'h204, NOP, 1'b0, 1'b0); adv();
    drive(32'h208, NOP, 1'b0, 1'b0);
    check_eq("c3_error",   {31'd0, error},   32'd0);
    check_eq("c3_correct", {31'd0, correct}, 32'd0);
    adv();
    drive(32'h20C, NOP, 1'b0, 1'b1);
    check_eq("c4_correct",   {31'd0, correct}, 32'd1);
    check_eq("c4_new_label", new_label,        32'h204);
    adv();

    // Reset asserted while error is high.
    drive(JAL_PC, JAL, 1'b0, 1'b0); adv();
    drive(JAL_PC, JAL, 1'b0, 1'b0); adv();
    drive(JAL_PC, JAL, 1'b0, 1'b0); adv();
    rst = 1'b1;
    drive(32'h204, NOP, 1'b0, 1'b0);
    check_eq("d3_error", {31'd0, error}, 32'd1);
    adv();
    rst = 1'b0;
    drive(32'h208, NOP, 1'b0, 1'b0);
    check_eq("d4_error",     {31'd0, error},   32'd0);
    check_eq("d4_correct",   {31'd0, correct}, 32'd0);
    check_eq("d4_new_label", new_label,        32'h4);
    adv();
    drive(32'h20C, NOP, 1'b0, 1'b0);
    check_eq("d5_error", {31'd0, error}, 32'd0);
    adv();
    drive(32'h210, NOP, 1'b0, 1'b0);
    check_eq("d6_error", {31'd0, error}, 32'd0);
    adv();
    run_br("e1", 1'b1, 1'b0);   // counter back at 01 -> 10
    run_br("e2", 1'b0, 1'b1);   // 10 predicts taken

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  function automatic logic [31:0] NOP_PC();
    return 32'h0000_0000;
  endfunction

endmodule
